multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width (power of 2, minimum 8).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1: operation request.
REQ-005 Port in_ready, output, 1: block can accept a request.
REQ-006 Port aluop, input, 4: operation select, sampled on acceptance.
REQ-007 Port vsrc1 and port vsrc2, inputs, WIDTH each: operands, sampled on acceptance.
REQ-008 Port out_valid, output, 1: result available.
REQ-009 Port out_ready, input, 1: consumer takes the result.
REQ-010 Port result, output, WIDTH: operation result.
REQ-011 Port zero, output, 1: result equals 0.
REQ-012 Port overflow, output, 1: signed overflow of ADD/SUB, 0 for all other ops.

Function
REQ-013 aluop encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed)
- 0101 XOR, 0110 NOR, 0111 SLTU
- 1000 SLL, 1001 SRL, 1010 SRA
- 1011 MULU (low WIDTH bits of the unsigned product)
- 1100 DIVU (quotient), 1101 REMU (remainder)
- 1110/1111: result 0, overflow 0.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and aluop are registered internally, and later input changes SHALL have no effect.
REQ-015 The FSM SHALL have three states with these transitions:
- IDLE -> DONE on acceptance of ops 0000-1010, 1110, 1111
- IDLE -> CALC on acceptance of 1011-1101
- CALC -> DONE after exactly WIDTH iteration cycles
- DONE -> IDLE on an edge with out_ready=1.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Single-cycle ops SHALL raise out_valid on the edge after acceptance (latency 1); MULU/DIVU/REMU SHALL raise it WIDTH+1 edges after acceptance.
REQ-018 result, zero and overflow SHALL be registered and held stable throughout DONE until out_ready is sampled high.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow=1 when the operand signs (vsrc2 inverted for SUB) agree and the result sign differs.
REQ-020 SLT/SLTU SHALL return 1 or 0 in bit 0 with upper bits 0; SLT SHALL be correct when the subtraction overflows.
REQ-021 Shift amount SHALL be vsrc2[log2(WIDTH)-1:0], applied to vsrc1; SRA SHALL replicate vsrc1 MSB.
REQ-022 MULU SHALL use iterative shift-add over one bit per CALC cycle; DIVU/REMU SHALL use restoring division, one quotient bit per CALC cycle.
REQ-023 Division by zero SHALL return quotient all-ones and remainder vsrc1, with the same latency as normal division.
REQ-024 zero SHALL equal (result == 0) for every op.
REQ-025 in_valid high while in_ready is low SHALL be ignored, with no queuing.

Reset
REQ-026 With rst=1 at an edge, the FSM SHALL enter IDLE and drive: in_ready=1 after that edge, out_valid=0, result=0, zero=0, overflow=0, iteration counter cleared.
REQ-027 Reset SHALL take priority over acceptance and completion in the same cycle.
REQ-028 Reset in CALC or DONE SHALL abort the operation, with no out_valid pulse afterwards.

Verification (WIDTH=32)
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1, zero 0, out_valid on the edge after acceptance.
REQ-030 SUB 5-5 -> result 0, zero 1, overflow 0; SLT 0xFFFFFFFF,0x00000001 -> 1; SLTU on the same operands -> 0; SRA 0x80000000 by 0x24 -> 0xF8000000.
REQ-031 MULU 0x00010000*0x00010000 -> result 0, zero 1, out_valid exactly 33 edges after acceptance, in_ready 0 throughout.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-033 Hold out_ready low for 5 cycles in DONE, changing vsrc1/vsrc2/in_valid meanwhile -> result stable and no new acceptance; out_ready=1 -> in_ready=1 on the next cycle.
REQ-034 Assert rst for one cycle 10 cycles into a MULU -> in_ready=1 and out_valid=0 next cycle; a following ADD 2+3 -> result 5.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready ALU. Most ops finish in one cycle; MULU,
// DIVU and REMU iterate one bit per cycle for WIDTH cycles.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] vsrc1,
  input  logic [WIDTH-1:0] vsrc2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_SLT  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_NOR  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MULU = 4'b1011,
    OP_DIVU = 4'b1100,
    OP_REMU = 4'b1101
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;   // product accumulator or partial remainder
  logic [WIDTH-1:0] x_q;   // multiplicand (shifts left) or divisor
  logic [WIDTH-1:0] y_q;   // multiplier (shifts right) or dividend/quotient
  logic [SW-1:0]    cnt;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [SW-1:0]    shamt;
  logic             is_multi;

  // Single-cycle result computed straight from the request inputs
  always_comb begin
    sum      = vsrc1 + vsrc2;
    diff     = vsrc1 - vsrc2;
    shamt    = vsrc2[SW-1:0];
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_multi = (aluop == OP_MULU) || (aluop == OP_DIVU) || (aluop == OP_REMU);
    case (aluop)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (vsrc1[WIDTH-1] == vsrc2[WIDTH-1]) && (sum[WIDTH-1] != vsrc1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (vsrc1[WIDTH-1] != vsrc2[WIDTH-1]) && (diff[WIDTH-1] != vsrc1[WIDTH-1]);
      end
      OP_AND:  alu_res = vsrc1 & vsrc2;
      OP_OR:   alu_res = vsrc1 | vsrc2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(vsrc1) < $signed(vsrc2))};
      OP_XOR:  alu_res = vsrc1 ^ vsrc2;
      OP_NOR:  alu_res = ~(vsrc1 | vsrc2);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (vsrc1 < vsrc2)};
      OP_SLL:  alu_res = vsrc1 << shamt;
      OP_SRL:  alu_res = vsrc1 >> shamt;
      OP_SRA:  alu_res = $signed(vsrc1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  logic [WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub, rem_nxt, quo_nxt, calc_res;

  // One shift-add or restoring-division step per CALC cycle
  always_comb begin
    mul_nxt = acc + (y_q[0] ? x_q : '0);
    rem_sh  = {acc, y_q[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, x_q};
    // When div_ge holds the true difference is below x_q, so WIDTH bits suffice.
    // A zero divisor always subtracts: quotient all ones, remainder = dividend.
    rem_sub = rem_sh[WIDTH-1:0] - x_q;
    rem_nxt = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
    quo_nxt = {y_q[WIDTH-2:0], div_ge};
    case (op_q)
      OP_MULU: calc_res = mul_nxt;
      OP_DIVU: calc_res = quo_nxt;
      default: calc_res = rem_nxt;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      acc       <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= aluop;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (is_multi) begin
              state <= CALC;
              acc   <= '0;
              x_q   <= (aluop == OP_MULU) ? vsrc1 : vsrc2;
              y_q   <= (aluop == OP_MULU) ? vsrc2 : vsrc1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
            end
          end
        end
        CALC: begin
          cnt <= cnt + SW'(1);
          if (op_q == OP_MULU) begin
            acc <= mul_nxt;
            x_q <= x_q << 1;
            y_q <= y_q >> 1;
          end else begin
            acc <= rem_nxt;
            y_q <= quo_nxt;
          end
          if (cnt == SW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= calc_res;
            zero      <= (calc_res == '0);
            overflow  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with a scoreboard queue and an
// independent monitor that checks each completed result handshake.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] vsrc1, vsrc2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
  } exp_t;

  exp_t exp_q[$];

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .vsrc1(vsrc1), .vsrc2(vsrc2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare each accepted result against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.r);
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          chk("overflow", {31'd0, overflow}, {31'd0, e.o});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eo, input bit push);
    @(negedge clk);
    aluop = op; vsrc1 = a; vsrc2 = b; in_valid = 1'b1;
    if (push) exp_q.push_back('{r: er, z: ez, o: eo});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vsrc1 = $urandom; vsrc2 = $urandom; aluop = 4'($urandom);
  endtask

  task automatic wait_done(input int elat);
    int n = 1;
    int busy_bad = 0;
    if (!out_valid && in_ready) busy_bad++;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (!out_valid && in_ready) busy_bad++;
    end
    chk("latency", n, elat);
    chk("in_ready_busy", busy_bad, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("back_to_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic eo, input int elat);
    issue(op, a, b, er, ez, eo, 1'b1);
    wait_done(elat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0;
    int bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluop = '0; vsrc1 = '0; vsrc2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1);
    run_op(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b0001, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
    run_op(4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1);
    run_op(4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1);
    run_op(4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
    run_op(4'b0100, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1);
    run_op(4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1);
    run_op(4'b0110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    run_op(4'b0110, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b1000, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1);
    run_op(4'b1001, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1);
    run_op(4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1);
    run_op(4'b1110, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b1111, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    run_op(4'b1011, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33);
    run_op(4'b1011, 32'd12345,    32'd100,      32'h0012D644, 1'b0, 1'b0, 33);
    run_op(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33);
    run_op(4'b1100, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33);
    run_op(4'b1101, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33);
    run_op(4'b1100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 33);
    run_op(4'b1101, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1'b0, 33);

    // Result must hold while the consumer stalls, ignoring new requests
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
    wait_done(1);
    r0 = result;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      vsrc1 = $urandom; vsrc2 = $urandom; aluop = 4'b0000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (result !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_value", r0, 32'd30);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset part-way through a MULU aborts it with no result
    issue(4'b1011, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("abort_no_valid", bad, 0);
    run_op(4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
